// File: rtl/sayac_mem_responder_if.sv
// SAYAC core <-> memory handshake bundle.
// The core drives the master side; the memory responder is the slave.
interface sayac_mem_responder_if;
    logic        readMEM;
    logic        writeMEM;
    logic [15:0] addrBus;
    logic [15:0] dataBusIn;
    logic [15:0] dataBusOut;
    logic        readyMEM;
    logic        protErr;

    modport master (
        output readMEM,
        output writeMEM,
        output addrBus,
        output dataBusIn,
        input  dataBusOut,
        input  readyMEM,
        input  protErr
    );

    modport slave (
        input  readMEM,
        input  writeMEM,
        input  addrBus,
        input  dataBusIn,
        output dataBusOut,
        output readyMEM,
        output protErr
    );
endinterface

// File: rtl/sayac_mem_responder.sv
// Word-addressed RAM responder for the SAYAC memory handshake.
// Serves read/write requests after WAIT_CYCLES wait states with a four-phase readyMEM ack.
module sayac_mem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    sayac_mem_responder_if.slave bus
);

    localparam int unsigned Depth    = 1 << ADDR_BITS;
    localparam logic [7:0]  WaitLoad = 8'(WAIT_CYCLES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 prot_err_q, prot_err_d;

    logic [15:0] mem_q [Depth];

    logic                 req;
    logic                 done_entry;
    logic [ADDR_BITS-1:0] op_addr;
    logic [15:0]          op_data;
    logic                 op_write;

    // Upper address bits are deliberately ignored (aliasing).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addrBus[15:ADDR_BITS];

    assign req = bus.readMEM | bus.writeMEM;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        prot_err_d = prot_err_q;
        done_entry = 1'b0;
        op_addr    = addr_q;
        op_data    = wdata_q;
        op_write   = is_write_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d     = bus.addrBus[ADDR_BITS-1:0];
                    wdata_d    = bus.dataBusIn;
                    is_write_d = bus.writeMEM;
                    if (bus.readMEM && bus.writeMEM) begin
                        prot_err_d = 1'b1;
                    end
                    if (WAIT_CYCLES == 0) begin
                        // Zero-wait completes on the capture edge with the live bus values.
                        done_entry = 1'b1;
                        op_addr    = bus.addrBus[ADDR_BITS-1:0];
                        op_data    = bus.dataBusIn;
                        op_write   = bus.writeMEM;
                        state_d    = StDone;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d    = StIdle;
                    cnt_d      = 8'd0;
                    prot_err_d = 1'b1;
                end else if (cnt_q == 8'd1) begin
                    done_entry = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                if (!req) begin
                    state_d = StIdle;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
            end
        endcase

        if (done_entry) begin
            ready_d = 1'b1;
            if (!op_write) begin
                rdata_d = mem_q[op_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            is_write_q <= 1'b0;
            rdata_q    <= 16'h0000;
            ready_q    <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            prot_err_q <= prot_err_d;
        end
    end

    // RAM is not reset, but a write must not land while reset is held.
    always_ff @(posedge clk) begin
        if (rst && done_entry && op_write) begin
            mem_q[op_addr] <= op_data;
        end
    end

    assign bus.dataBusOut = rdata_q;
    assign bus.readyMEM   = ready_q;
    assign bus.protErr    = prot_err_q;

endmodule

// File: tb/tb_sayac_mem_responder.sv
// Bench for sayac_mem_responder: one stimulus stream drives a zero-wait and a two-wait instance,
// each checked every cycle against a transaction-level model.
module tb_sayac_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_r = 1'b0;
    logic        tb_w = 1'b0;
    logic [15:0] tb_a = 16'h0000;
    logic [15:0] tb_d = 16'h0000;

    sayac_mem_responder_if if0 ();
    sayac_mem_responder_if if2 ();

    assign if0.readMEM   = tb_r;
    assign if0.writeMEM  = tb_w;
    assign if0.addrBus   = tb_a;
    assign if0.dataBusIn = tb_d;
    assign if2.readMEM   = tb_r;
    assign if2.writeMEM  = tb_w;
    assign if2.addrBus   = tb_a;
    assign if2.dataBusIn = tb_d;

    sayac_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sayac_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: index 0 = zero-wait instance, 1 = two-wait instance.
    bit          m_busy [2];
    bit          m_ack  [2];
    bit          m_wr   [2];
    bit          m_prot [2];
    int          m_age  [2];
    logic [9:0]  m_addr [2];
    logic [15:0] m_data [2];
    logic [15:0] m_rdata[2];
    logic [15:0] m_mem  [2][1024];

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic m_finish(input int d);
        m_busy[d] = 1'b0;
        m_ack[d]  = 1'b1;
        if (m_wr[d]) m_mem[d][m_addr[d]] = m_data[d];
        else         m_rdata[d] = m_mem[d][m_addr[d]];
    endtask

    task automatic m_edge(input int d);
        if (m_ack[d]) begin
            if (!tb_r && !tb_w) m_ack[d] = 1'b0;
        end else if (m_busy[d]) begin
            if (!tb_r && !tb_w) begin
                m_busy[d] = 1'b0;
                m_prot[d] = 1'b1;
            end else begin
                m_age[d]++;
                if (m_age[d] == wait_of(d)) m_finish(d);
            end
        end else if (tb_r || tb_w) begin
            m_wr[d]   = tb_w;
            m_addr[d] = tb_a[9:0];
            m_data[d] = tb_d;
            if (tb_r && tb_w) m_prot[d] = 1'b1;
            m_age[d]  = 0;
            m_busy[d] = 1'b1;
            if (wait_of(d) == 0) m_finish(d);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_busy[d]  = 1'b0;
                m_ack[d]   = 1'b0;
                m_prot[d]  = 1'b0;
                m_rdata[d] = 16'h0000;
            end else begin
                m_edge(d);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && rst) begin
            chk("ready0", {15'd0, if0.readyMEM}, {15'd0, m_ack[0]});
            chk("ready2", {15'd0, if2.readyMEM}, {15'd0, m_ack[1]});
            chk("prot0", {15'd0, if0.protErr}, {15'd0, m_prot[0]});
            chk("prot2", {15'd0, if2.protErr}, {15'd0, m_prot[1]});
            chk("dout0", if0.dataBusOut, m_rdata[0]);
            chk("dout2", if2.dataBusOut, m_rdata[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        tb_r = r;
        tb_w = w;
        tb_a = a;
        tb_d = d;
    endtask

    // Holds the request for h edges (capture edge included), then drops it for one edge.
    task automatic hold_req(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input int h, input bit jitter);
        drive(r, w, a, d);
        for (int i = 0; i < h; i++) begin
            step();
            if (jitter && i < h - 1) begin
                if ($urandom_range(1) == 1) tb_a = 16'($urandom);
                if ($urandom_range(1) == 1) tb_d = 16'($urandom);
                if ($urandom_range(7) == 0) begin
                    tb_r = !tb_r;
                    tb_w = !tb_r;
                end
            end
        end
        drive(1'b0, 1'b0, tb_a, tb_d);
        step();
    endtask

    // Holds the request until the two-wait instance acks, records the ack edge of each instance.
    task automatic xact(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int extra, input bit move_addr, output int e0, output int e2);
        e0 = -1;
        e2 = -1;
        drive(r, w, a, d);
        for (int n = 1; n <= 10 && e2 < 0; n++) begin
            step();
            if (e0 < 0 && if0.readyMEM) e0 = n;
            if (e2 < 0 && if2.readyMEM) e2 = n;
        end
        if (e2 < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_timeout: got no readyMEM required within 10 edges at %0t", $time);
        end
        for (int i = 0; i < extra; i++) begin
            if (move_addr) tb_a = tb_a + 16'd1;
            step();
            chk("held_ready0", {15'd0, if0.readyMEM}, 16'd1);
            chk("held_ready2", {15'd0, if2.readyMEM}, 16'd1);
        end
        drive(1'b0, 1'b0, tb_a, tb_d);
        step();
    endtask

    initial begin
        int  e0;
        int  e2;
        bit  seen;
        int  sel;
        int  h;
        logic rr;
        logic ww;

        #2 rst = 1'b0;
        #1;
        chk("rst_ready0", {15'd0, if0.readyMEM}, 16'd0);
        chk("rst_ready2", {15'd0, if2.readyMEM}, 16'd0);
        chk("rst_dout0", if0.dataBusOut, 16'h0000);
        chk("rst_dout2", if2.dataBusOut, 16'h0000);
        chk("rst_prot0", {15'd0, if0.protErr}, 16'd0);
        chk("rst_prot2", {15'd0, if2.protErr}, 16'd0);
        step();
        step();
        rst    = 1'b1;
        chk_en = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if0.readyMEM || if2.readyMEM) seen = 1'b1;
        end
        chk("idle_no_ready", {15'd0, seen}, 16'd0);

        for (int i = 0; i < 16; i++) begin
            hold_req(1'b0, 1'b1, 16'(i), 16'h1000 + 16'(i), 4, 1'b0);
        end

        xact(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, 1'b0, e0, e2);
        chk("wr_lat2", 16'(e2), 16'd3);
        chk("wr_lat0", 16'(e0), 16'd1);
        xact(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, e0, e2);
        chk("rd_lat2", 16'(e2), 16'd3);
        chk("rd_lat0", 16'(e0), 16'd1);
        chk("rd_beef0", if0.dataBusOut, 16'hBEEF);
        chk("rd_beef2", if2.dataBusOut, 16'hBEEF);
        chk("rd_prot0", {15'd0, if0.protErr}, 16'd0);
        chk("rd_prot2", {15'd0, if2.protErr}, 16'd0);

        xact(1'b0, 1'b1, 16'h0403, 16'h1234, 0, 1'b0, e0, e2);
        xact(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1'b0, e0, e2);
        chk("alias0", if0.dataBusOut, 16'h1234);
        chk("alias2", if2.dataBusOut, 16'h1234);

        xact(1'b1, 1'b0, 16'h0005, 16'h0000, 4, 1'b1, e0, e2);
        chk("held_dout0", if0.dataBusOut, 16'hBEEF);
        chk("held_dout2", if2.dataBusOut, 16'hBEEF);

        // Two-edge write: aborts on the two-wait instance, completes on the zero-wait one.
        hold_req(1'b0, 1'b1, 16'h0007, 16'hAAAA, 2, 1'b0);
        chk("abort_prot2", {15'd0, if2.protErr}, 16'd1);
        chk("abort_prot0", {15'd0, if0.protErr}, 16'd0);
        xact(1'b1, 1'b0, 16'h0007, 16'h0000, 0, 1'b0, e0, e2);
        chk("abort_keep2", if2.dataBusOut, 16'h1007);
        chk("abort_done0", if0.dataBusOut, 16'hAAAA);

        for (int t = 0; t < 250; t++) begin
            sel = int'($urandom_range(9));
            rr  = (sel < 5) || (sel == 9);
            ww  = (sel >= 5);
            h   = ($urandom_range(9) < 3) ? int'($urandom_range(2, 1)) :
                                            int'($urandom_range(6, 3));
            hold_req(rr, ww, (16'($urandom) & 16'hFC00) | 16'($urandom_range(15)),
                     16'($urandom), h, 1'b1);
            for (int g = 0; g < int'($urandom_range(2)); g++) step();
        end

        #1 rst = 1'b0;
        #1 rst = 1'b1;
        chk("clr_prot0", {15'd0, if0.protErr}, 16'd0);
        chk("clr_prot2", {15'd0, if2.protErr}, 16'd0);
        step();

        hold_req(1'b1, 1'b1, 16'h0009, 16'h5555, 4, 1'b0);
        chk("dual_prot0", {15'd0, if0.protErr}, 16'd1);
        chk("dual_prot2", {15'd0, if2.protErr}, 16'd1);
        xact(1'b1, 1'b0, 16'h0009, 16'h0000, 0, 1'b0, e0, e2);
        chk("dual_wr0", if0.dataBusOut, 16'h5555);
        chk("dual_wr2", if2.dataBusOut, 16'h5555);

        drive(1'b1, 1'b0, 16'h0003, 16'h0000);
        step();
        step();
        chk("mid_ready0_pre", {15'd0, if0.readyMEM}, 16'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_ready0", {15'd0, if0.readyMEM}, 16'd0);
        chk("mid_ready2", {15'd0, if2.readyMEM}, 16'd0);
        chk("mid_dout0", if0.dataBusOut, 16'h0000);
        chk("mid_dout2", if2.dataBusOut, 16'h0000);
        chk("mid_prot0", {15'd0, if0.protErr}, 16'd0);
        chk("mid_prot2", {15'd0, if2.protErr}, 16'd0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        rst = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
